wb_burst_reader: RTL and testbench
==================================

WB_BURST_READER -- requirements
Module: wb_burst_reader

Interface
REQ-001 Parameters: WB_ADDR_BITS, default 32, wishbone address width.
REQ-002 Parameters: WORD_BYTES, default 4, bytes per word; WORD_BITS = 8*WORD_BYTES.
REQ-003 Parameters: LEN_BITS, default 8, width of the word-count field.
REQ-004 Parameters: BURST_CTI, default 3'b010, incrementing-burst cycle type; BURST_BTE, default 2'b00, linear burst.
REQ-005 Ports: one clock, wbm_clk_i, input, 1, all state updates on its rising edge.
REQ-006 Ports: reset is asynchronous and active-high, wbm_rst_i, input, 1.
REQ-007 Ports: req_i, input, 1, start request, sampled in IDLE only.
REQ-008 Ports: req_addr_i, input, [WB_ADDR_BITS-1:2], first word address.
REQ-009 Ports: req_len_i, input, LEN_BITS, number of words to read.
REQ-010 Ports: busy_o, output, 1, high whenever state is not IDLE.
REQ-011 Ports: done_o, output, 1, one-cycle completion pulse.
REQ-012 Ports: data_o, output, WORD_BITS, last captured word; data_valid_o, output, 1, one-cycle strobe per captured word.
REQ-013 Ports: wbm_cyc_o and wbm_stb_o, outputs, 1 each, wishbone master cycle and strobe.
REQ-014 Ports: wbm_addr_o, output, [WB_ADDR_BITS-1:2], current word address.
REQ-015 Ports: wbm_cti_o, output, 3, cycle type; wbm_bte_o, output, 2, burst type.
REQ-016 Ports: wbm_sel_o, output, WORD_BYTES, byte selects; wbm_we_o, output, 1, write enable.
REQ-017 Ports: wbm_data_i, input, WORD_BITS, read data; wbm_ack_i, input, 1, slave acknowledge.

Function
REQ-018 The block SHALL implement the states IDLE, BURST and DONE.
REQ-019 IDLE with req_i=1 and req_len_i!=0 -> SHALL latch req_addr_i into the address register and req_len_i into the remaining counter, then go to BURST.
REQ-020 IDLE with req_i=1 and req_len_i=0 -> SHALL go to DONE with no bus cycle.
REQ-021 req_i SHALL be ignored in BURST and DONE; it is not queued.
REQ-022 In BURST: wbm_cyc_o=wbm_stb_o=1, wbm_we_o=0, wbm_sel_o all ones, wbm_bte_o=BURST_BTE.
REQ-023 In BURST: wbm_cti_o=BURST_CTI while remaining>1, and 3'b111 when remaining==1 (including single-word requests).
REQ-024 Outside BURST: wbm_cyc_o=wbm_stb_o=0 and wbm_cti_o=3'b000; all wishbone outputs SHALL be registered.
REQ-025 On each BURST cycle with wbm_ack_i=1: data_o<=wbm_data_i; data_valid_o=1 the next cycle; address increments by 1; remaining decrements by 1.
REQ-026 The bus outputs for the next word SHALL be visible the cycle after the ack, so a slave that acks every cycle sustains one word per cycle.
REQ-027 wbm_ack_i=0 in BURST (wait state) SHALL hold every bus output unchanged.
REQ-028 The ack with remaining==1 SHALL deassert cyc/stb the next cycle and enter DONE.
REQ-029 wbm_ack_i outside BURST SHALL be ignored: no capture and no strobe.
REQ-030 The address SHALL increment modulo 2^(WB_ADDR_BITS-2), so all-ones wraps to 0 with no error.
REQ-031 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-032 A new request SHALL be accepted the cycle after done_o is asserted.

Reset
REQ-033 wbm_rst_i=1 SHALL immediately force IDLE, cyc/stb/we/done_o/data_valid_o/busy_o=0, cti=0, bte=0, sel=0, addr=0, data_o=0, remaining=0.
REQ-034 Reset mid-burst SHALL drop cyc/stb without waiting for ack; no done_o is issued for the aborted request.

Verification
REQ-035 Four-word read: req_addr=0x100, len=4, ack every cycle -> addr 0x100..0x103, cti 010,010,010,111, four data_valid_o pulses, done_o one cycle after the data_valid_o of the last word.
REQ-036 Wait states: len=3, ack low 2 cycles before each word -> outputs held while ack is low; data_o matches the slave word on each strobe; exactly 3 strobes.
REQ-037 Zero and one length: len=0 -> done_o with no cyc assertion; len=1 -> single cycle with cti=111, one strobe.
REQ-038 Wrap and ignore: addr=all-ones, len=2 -> second address is 0; req_i pulsed during BURST -> no effect.
REQ-039 Reset mid-burst: assert wbm_rst_i after 2 acks of len=8 -> cyc=0 at once, no done_o; a later len=1 request completes normally.

Source files
------------

// File: rtl/wb_burst_reader.sv
// Wishbone classic-burst read master: fetches req_len_i consecutive words from req_addr_i
// with incrementing bursts and registered bus outputs, one word per acked cycle.
module wb_burst_reader #(
    parameter int unsigned WB_ADDR_BITS = 32,
    parameter int unsigned WORD_BYTES   = 4,
    parameter int unsigned LEN_BITS     = 8,
    parameter logic [2:0]  BURST_CTI    = 3'b010,
    parameter logic [1:0]  BURST_BTE    = 2'b00
) (
    input  logic                      wbm_clk_i,
    input  logic                      wbm_rst_i,
    input  logic                      req_i,
    input  logic [WB_ADDR_BITS-1:2]   req_addr_i,
    input  logic [LEN_BITS-1:0]       req_len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [8*WORD_BYTES-1:0]   data_o,
    output logic                      data_valid_o,
    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic [WB_ADDR_BITS-1:2]   wbm_addr_o,
    output logic [2:0]                wbm_cti_o,
    output logic [1:0]                wbm_bte_o,
    output logic [WORD_BYTES-1:0]     wbm_sel_o,
    output logic                      wbm_we_o,
    input  logic [8*WORD_BYTES-1:0]   wbm_data_i,
    input  logic                      wbm_ack_i
);

    localparam int unsigned ADDR_W = WB_ADDR_BITS - 2;
    localparam logic [2:0]  CTI_END = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [LEN_BITS-1:0]       remaining, remaining_nxt;
    logic [WB_ADDR_BITS-1:2]   addr_nxt;
    logic                      cyc_nxt, stb_nxt, we_nxt;
    logic [2:0]                cti_nxt;
    logic [1:0]                bte_nxt;
    logic [WORD_BYTES-1:0]     sel_nxt;
    logic [8*WORD_BYTES-1:0]   data_nxt;
    logic                      data_valid_nxt, done_nxt;

    assign busy_o = (state != S_IDLE);

    // Bus outputs default to their current register values so a wait state holds them.
    always_comb begin
        state_nxt      = state;
        remaining_nxt  = remaining;
        addr_nxt       = wbm_addr_o;
        cyc_nxt        = wbm_cyc_o;
        stb_nxt        = wbm_stb_o;
        we_nxt         = wbm_we_o;
        cti_nxt        = wbm_cti_o;
        bte_nxt        = wbm_bte_o;
        sel_nxt        = wbm_sel_o;
        data_nxt       = data_o;
        data_valid_nxt = 1'b0;
        done_nxt       = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_i) begin
                    if (req_len_i != '0) begin
                        state_nxt     = S_BURST;
                        addr_nxt      = req_addr_i;
                        remaining_nxt = req_len_i;
                        cyc_nxt       = 1'b1;
                        stb_nxt       = 1'b1;
                        we_nxt        = 1'b0;
                        sel_nxt       = '1;
                        bte_nxt       = BURST_BTE;
                        cti_nxt       = (req_len_i == LEN_BITS'(1)) ? CTI_END : BURST_CTI;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end

            S_BURST: begin
                if (wbm_ack_i) begin
                    data_nxt       = wbm_data_i;
                    data_valid_nxt = 1'b1;
                    addr_nxt       = wbm_addr_o + ADDR_W'(1);
                    remaining_nxt  = remaining - LEN_BITS'(1);
                    if (remaining == LEN_BITS'(1)) begin
                        state_nxt = S_DONE;
                        cyc_nxt   = 1'b0;
                        stb_nxt   = 1'b0;
                        cti_nxt   = 3'b000;
                        bte_nxt   = 2'b00;
                        sel_nxt   = '0;
                    end else begin
                        // cti must already flag end-of-burst while the final word is on the bus
                        cti_nxt = (remaining == LEN_BITS'(2)) ? CTI_END : BURST_CTI;
                    end
                end
            end

            S_DONE: begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
                cyc_nxt   = 1'b0;
                stb_nxt   = 1'b0;
                cti_nxt   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge wbm_clk_i or posedge wbm_rst_i) begin
        if (wbm_rst_i) begin
            state        <= S_IDLE;
            remaining    <= '0;
            wbm_addr_o   <= '0;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            wbm_we_o     <= 1'b0;
            wbm_cti_o    <= 3'b000;
            wbm_bte_o    <= 2'b00;
            wbm_sel_o    <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state        <= state_nxt;
            remaining    <= remaining_nxt;
            wbm_addr_o   <= addr_nxt;
            wbm_cyc_o    <= cyc_nxt;
            wbm_stb_o    <= stb_nxt;
            wbm_we_o     <= we_nxt;
            wbm_cti_o    <= cti_nxt;
            wbm_bte_o    <= bte_nxt;
            wbm_sel_o    <= sel_nxt;
            data_o       <= data_nxt;
            data_valid_o <= data_valid_nxt;
            done_o       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_wb_burst_reader.sv
// Bench for wb_burst_reader: a wait-state-capable slave model plus a scoreboard of
// expected beat addresses, cycle types and captured words.
module tb_wb_burst_reader;

    localparam int unsigned AW = 32;
    localparam int unsigned WB = 4;
    localparam int unsigned LB = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic [AW-1:2]     req_addr = '0;
    logic [LB-1:0]     req_len = '0;
    logic              busy_o, done_o, data_valid_o;
    logic [8*WB-1:0]   data_o;
    logic              wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [AW-1:2]     wbm_addr_o;
    logic [2:0]        wbm_cti_o;
    logic [1:0]        wbm_bte_o;
    logic [WB-1:0]     wbm_sel_o;
    logic [8*WB-1:0]   wbm_data = '0;
    logic              wbm_ack = 1'b0;

    int unsigned checks = 0, passes = 0;
    int unsigned cycle = 0;
    int unsigned strobes = 0, dones = 0, cyc_cycles = 0;
    int unsigned last_dv_cycle = 0, last_done_cycle = 0;
    int unsigned slave_waits = 0;
    bit          stray_ack = 1'b0;

    logic [29:0] exp_addr[$];
    logic [2:0]  exp_cti[$];
    logic [31:0] exp_data[$];

    wb_burst_reader #(
        .WB_ADDR_BITS(AW),
        .WORD_BYTES(WB),
        .LEN_BITS(LB),
        .BURST_CTI(3'b010),
        .BURST_BTE(2'b00)
    ) dut (
        .wbm_clk_i(clk),
        .wbm_rst_i(rst),
        .req_i(req),
        .req_addr_i(req_addr),
        .req_len_i(req_len),
        .busy_o(busy_o),
        .done_o(done_o),
        .data_o(data_o),
        .data_valid_o(data_valid_o),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_addr_o(wbm_addr_o),
        .wbm_cti_o(wbm_cti_o),
        .wbm_bte_o(wbm_bte_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o),
        .wbm_data_i(wbm_data),
        .wbm_ack_i(wbm_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    function automatic logic [31:0] word_of(input logic [29:0] a);
        return ({2'b00, a} * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    // Slave model: inserts slave_waits idle cycles before every ack.
    logic [29:0] held_addr;
    logic [2:0]  held_cti;
    bit          prev_wait = 1'b0;
    int unsigned wait_cnt = 0;
    always @(negedge clk) begin
        logic [29:0] ea;
        logic [2:0]  ec;
        if (rst) begin
            wbm_ack   = 1'b0;
            wait_cnt  = 0;
            prev_wait = 1'b0;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            if (prev_wait) begin
                checks++;
                if (wbm_addr_o !== held_addr || wbm_cti_o !== held_cti)
                    $display("FAIL hold: addr=%h cti=%b, required addr=%h cti=%b",
                             wbm_addr_o, wbm_cti_o, held_addr, held_cti);
                else passes++;
            end
            if (wait_cnt < slave_waits) begin
                wbm_ack   = 1'b0;
                wait_cnt++;
                prev_wait = 1'b1;
                held_addr = wbm_addr_o;
                held_cti  = wbm_cti_o;
                wbm_data  = $urandom;
            end else begin
                wbm_ack   = 1'b1;
                wait_cnt  = 0;
                prev_wait = 1'b0;
                wbm_data  = word_of(wbm_addr_o);
                checks++;
                if (exp_addr.size() == 0) begin
                    $display("FAIL beat: unexpected bus beat addr=%h, required no beat", wbm_addr_o);
                end else begin
                    ea = exp_addr.pop_front();
                    ec = exp_cti.pop_front();
                    if (wbm_addr_o !== ea || wbm_cti_o !== ec || wbm_we_o !== 1'b0 ||
                        wbm_sel_o !== 4'hF || wbm_bte_o !== 2'b00)
                        $display("FAIL beat: addr=%h cti=%b we=%b sel=%h bte=%b, required addr=%h cti=%b we=0 sel=f bte=00",
                                 wbm_addr_o, wbm_cti_o, wbm_we_o, wbm_sel_o, wbm_bte_o, ea, ec);
                    else passes++;
                end
            end
        end else begin
            wbm_ack   = stray_ack;
            prev_wait = 1'b0;
            wait_cnt  = 0;
            wbm_data  = stray_ack ? 32'hDEAD_BEEF : $urandom;
        end
    end

    // Output monitor: every strobe pops and compares the next expected word.
    always @(negedge clk) begin
        logic [31:0] ed;
        if (!rst) begin
            if (wbm_cyc_o) cyc_cycles++;
            if (done_o) begin
                dones++;
                last_done_cycle = cycle;
            end
            if (data_valid_o) begin
                strobes++;
                last_dv_cycle = cycle;
                checks++;
                if (exp_data.size() == 0) begin
                    $display("FAIL data: unexpected strobe data=%h, required no strobe", data_o);
                end else begin
                    ed = exp_data.pop_front();
                    if (data_o !== ed)
                        $display("FAIL data: got %h, required %h", data_o, ed);
                    else passes++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [29:0] a, input logic [7:0] n);
        logic [29:0] x;
        x = a;
        for (int i = 0; i < int'(n); i++) begin
            exp_addr.push_back(x);
            exp_cti.push_back((i == int'(n) - 1) ? 3'b111 : 3'b010);
            exp_data.push_back(word_of(x));
            x = x + 30'd1;
        end
        req      = 1'b1;
        req_addr = a;
        req_len  = n;
        tick();
        req      = 1'b0;
        req_addr = 30'($urandom);
        req_len  = 8'($urandom);
    endtask

    // Returns at the cycle where done_o is high, or with ok=0 after budget cycles.
    task automatic wait_done(input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (done_o === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [127:0] snap;
        rst = 1'b1;
        tick();
        tick();
        snap = {busy_o, done_o, data_valid_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o,
                wbm_bte_o, wbm_sel_o, wbm_addr_o, data_o};
        checks++;
        if (snap !== '0) $display("FAIL reset_state: outputs=%h, required 0", snap);
        else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_four_word();
        int unsigned s0, c0, d0;
        bit ok;
        slave_waits = 0;
        s0 = strobes; c0 = cyc_cycles; d0 = dones;
        issue(30'h100, 8'd4);
        checks++;
        if (busy_o !== 1'b1) $display("FAIL four_busy: busy=%b, required 1", busy_o);
        else passes++;
        wait_done(50, ok);
        checks++;
        if (!ok) $display("FAIL four_done: done_o not seen in 50 cycles, required pulse");
        else passes++;
        tick();
        checks++;
        if (strobes - s0 !== 4 || cyc_cycles - c0 !== 4 || dones - d0 !== 1)
            $display("FAIL four_counts: strobes=%0d cyc=%0d done=%0d, required 4 4 1",
                     strobes - s0, cyc_cycles - c0, dones - d0);
        else passes++;
        checks++;
        if (last_done_cycle !== last_dv_cycle + 1)
            $display("FAIL four_done_timing: done at %0d, required %0d",
                     last_done_cycle, last_dv_cycle + 1);
        else passes++;
    endtask

    task automatic test_wait_states();
        int unsigned s0, c0, d0;
        bit ok;
        slave_waits = 2;
        s0 = strobes; c0 = cyc_cycles; d0 = dones;
        issue(30'h2000, 8'd3);
        wait_done(100, ok);
        checks++;
        if (!ok) $display("FAIL wait_done: done_o not seen in 100 cycles, required pulse");
        else passes++;
        tick();
        checks++;
        if (strobes - s0 !== 3 || cyc_cycles - c0 !== 9 || dones - d0 !== 1)
            $display("FAIL wait_counts: strobes=%0d cyc=%0d done=%0d, required 3 9 1",
                     strobes - s0, cyc_cycles - c0, dones - d0);
        else passes++;
        slave_waits = 0;
    endtask

    task automatic test_zero_one();
        int unsigned s0, c0, d0;
        logic [31:0] keep;
        bit ok;
        s0 = strobes; c0 = cyc_cycles; d0 = dones;
        issue(30'h444, 8'd0);
        wait_done(10, ok);
        tick();
        checks++;
        if (!ok || cyc_cycles - c0 !== 0 || strobes - s0 !== 0 || dones - d0 !== 1)
            $display("FAIL zero_len: ok=%0d cyc=%0d strobes=%0d done=%0d, required 1 0 0 1",
                     ok, cyc_cycles - c0, strobes - s0, dones - d0);
        else passes++;
        keep = data_o;
        s0 = strobes;
        stray_ack = 1'b1;
        repeat (3) tick();
        stray_ack = 1'b0;
        tick();
        checks++;
        if (strobes - s0 !== 0 || data_o !== keep)
            $display("FAIL idle_ack: strobes=%0d data=%h, required 0 %h", strobes - s0, data_o, keep);
        else passes++;
        s0 = strobes; c0 = cyc_cycles; d0 = dones;
        issue(30'h777, 8'd1);
        wait_done(20, ok);
        tick();
        checks++;
        if (!ok || strobes - s0 !== 1 || cyc_cycles - c0 !== 1 || dones - d0 !== 1)
            $display("FAIL one_len: ok=%0d strobes=%0d cyc=%0d done=%0d, required 1 1 1 1",
                     ok, strobes - s0, cyc_cycles - c0, dones - d0);
        else passes++;
    endtask

    task automatic test_wrap_ignore();
        int unsigned s0, d0;
        bit ok;
        slave_waits = 1;
        s0 = strobes; d0 = dones;
        issue('1, 8'd2);
        tick();
        req = 1'b1; req_addr = 30'h55; req_len = 8'd5;
        tick();
        req = 1'b0;
        wait_done(50, ok);
        tick();
        tick();
        checks++;
        if (!ok || strobes - s0 !== 2 || dones - d0 !== 1 || busy_o !== 1'b0)
            $display("FAIL wrap_ignore: ok=%0d strobes=%0d done=%0d busy=%b, required 1 2 1 0",
                     ok, strobes - s0, dones - d0, busy_o);
        else passes++;
        checks++;
        if (exp_addr.size() != 0 || exp_data.size() != 0)
            $display("FAIL wrap_pending: beats=%0d words=%0d outstanding, required 0 0",
                     exp_addr.size(), exp_data.size());
        else passes++;
        slave_waits = 0;
    endtask

    task automatic test_back_to_back();
        int unsigned s0, d0;
        bit ok;
        s0 = strobes; d0 = dones;
        issue(30'h40, 8'd2);
        wait_done(30, ok);
        issue(30'h80, 8'd1);
        checks++;
        if (!ok || busy_o !== 1'b1)
            $display("FAIL b2b_accept: ok=%0d busy=%b, required 1 1", ok, busy_o);
        else passes++;
        wait_done(30, ok);
        tick();
        checks++;
        if (!ok || strobes - s0 !== 3 || dones - d0 !== 2)
            $display("FAIL b2b_counts: ok=%0d strobes=%0d done=%0d, required 1 3 2",
                     ok, strobes - s0, dones - d0);
        else passes++;
    endtask

    task automatic test_reset_mid_burst();
        int unsigned s0, d0;
        bit ok;
        logic [63:0] snap;
        slave_waits = 0;
        s0 = strobes;
        issue(30'h300, 8'd8);
        for (int i = 0; i < 20 && strobes - s0 < 2; i++) tick();
        checks++;
        if (strobes - s0 < 2) $display("FAIL mid_progress: strobes=%0d, required 2", strobes - s0);
        else passes++;
        rst = 1'b1;
        #1;
        snap = {busy_o, done_o, data_valid_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_addr_o};
        checks++;
        if (snap !== '0) $display("FAIL mid_reset: outputs=%h, required 0", snap);
        else passes++;
        exp_addr.delete();
        exp_cti.delete();
        exp_data.delete();
        d0 = dones;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (dones !== d0 || busy_o !== 1'b0)
            $display("FAIL mid_no_done: done=%0d busy=%b, required 0 0", dones - d0, busy_o);
        else passes++;
        s0 = strobes;
        issue(30'h310, 8'd1);
        wait_done(20, ok);
        tick();
        checks++;
        if (!ok || strobes - s0 !== 1 || dones - d0 !== 1)
            $display("FAIL after_reset: ok=%0d strobes=%0d done=%0d, required 1 1 1",
                     ok, strobes - s0, dones - d0);
        else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at 200000, required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_four_word();
        test_wait_states();
        test_zero_one();
        test_wrap_ignore();
        test_back_to_back();
        test_reset_mid_burst();
        repeat (2) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
